// File: rtl/gmii_rx_frame_receiver_if.sv
// rtl/gmii_rx_frame_receiver_if.sv - GMII receive inputs and payload stream/status outputs of the frame receiver
interface gmii_rx_frame_receiver_if;
    logic       i_gmii_rx_dv;
    logic [7:0] i_gmii_rx_d;
    logic       i_gmii_rx_err;
    logic [7:0] o_m_axis_tdata;
    logic       o_m_axis_tvalid;
    logic       o_m_axis_tlast;
    logic       o_m_axis_tuser;
    logic       o_frame_good;
    logic       o_frame_bad;

    modport master (
        input  i_gmii_rx_dv,
        input  i_gmii_rx_d,
        input  i_gmii_rx_err,
        output o_m_axis_tdata,
        output o_m_axis_tvalid,
        output o_m_axis_tlast,
        output o_m_axis_tuser,
        output o_frame_good,
        output o_frame_bad
    );

    modport slave (
        output i_gmii_rx_dv,
        output i_gmii_rx_d,
        output i_gmii_rx_err,
        input  o_m_axis_tdata,
        input  o_m_axis_tvalid,
        input  o_m_axis_tlast,
        input  o_m_axis_tuser,
        input  o_frame_good,
        input  o_frame_bad
    );
endinterface

// File: rtl/gmii_rx_frame_receiver.sv
// rtl/gmii_rx_frame_receiver.sv - GMII rx: strip preamble/SFD, check length and FCS, stream payload without the FCS
module gmii_rx_frame_receiver #(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    gmii_rx_frame_receiver_if.master io_bus
);

    localparam int          CW      = $clog2(MAX_FRAME_BYTES + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_FRAME_BYTES + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_FRAME_BYTES);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME_BYTES);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_sfd;
    logic          w_shift;
    logic          w_eof;
    logic          w_bad;

    logic [31:0]   r_crc;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic [7:0]    r_pd [5];
    logic [4:0]    r_pv;

    logic [7:0]    r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic          r_tuser;
    logic          r_good;
    logic          r_bad;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
            else             c = c >> 1;
        end
        return c;
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_DROP;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_sfd   = 1'b0;
        w_shift = 1'b0;
        w_eof   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.i_gmii_rx_dv) begin
                    if (io_bus.i_gmii_rx_d == PRE_BYTE && !io_bus.i_gmii_rx_err) w_next = S_PREAMBLE;
                    else                                                          w_next = S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!io_bus.i_gmii_rx_dv)               w_next = S_IDLE;
                else if (io_bus.i_gmii_rx_err)          w_next = S_DROP;
                else if (io_bus.i_gmii_rx_d == PRE_BYTE) w_next = S_PREAMBLE;
                else if (io_bus.i_gmii_rx_d == SFD_BYTE) begin
                    w_next = S_PAYLOAD;
                    w_sfd  = 1'b1;
                end else                                w_next = S_DROP;
            end
            S_PAYLOAD: begin
                if (io_bus.i_gmii_rx_dv) begin
                    w_shift = 1'b1;
                end else begin
                    w_eof  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_DROP: begin
                if (!io_bus.i_gmii_rx_dv) w_next = S_IDLE;
            end
            default: w_next = S_DROP;
        endcase
    end

    // CRC over data plus its own FCS leaves the fixed residue when the frame is intact
    assign w_bad = (r_crc != CRC_RESIDUE) || r_err || (r_count < CNT_MIN) || (r_count > CNT_MAX);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_crc    <= CRC_INIT;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_pv     <= '0;
            for (int i = 0; i < 5; i++) r_pd[i] <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            r_good   <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            r_good   <= 1'b0;
            r_bad    <= 1'b0;

            if (w_sfd) begin
                r_crc   <= CRC_INIT;
                r_count <= '0;
                r_err   <= 1'b0;
                r_pv    <= '0;
            end

            if (w_shift) begin
                r_crc   <= crc_next(r_crc, io_bus.i_gmii_rx_d);
                if (r_count != CNT_SAT) r_count <= r_count + CW'(1);
                if (io_bus.i_gmii_rx_err) r_err <= 1'b1;
                r_pd[0] <= io_bus.i_gmii_rx_d;
                for (int i = 1; i < 5; i++) r_pd[i] <= r_pd[i-1];
                r_pv    <= {r_pv[3:0], 1'b1};
                // p4 only fills once four newer bytes exist, so it can never be an FCS byte
                if (r_pv[4]) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_pd[4];
                end
            end

            if (w_eof) begin
                if (r_pv[4]) begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= r_pd[4];
                    r_tlast  <= 1'b1;
                    r_tuser  <= w_bad;
                end
                r_good <= !w_bad;
                r_bad  <= w_bad;
                r_pv   <= '0;
            end
        end
    end

    assign io_bus.o_m_axis_tdata  = r_tdata;
    assign io_bus.o_m_axis_tvalid = r_tvalid;
    assign io_bus.o_m_axis_tlast  = r_tlast;
    assign io_bus.o_m_axis_tuser  = r_tuser;
    assign io_bus.o_frame_good    = r_good;
    assign io_bus.o_frame_bad     = r_bad;

endmodule

// File: tb/tb_gmii_rx_frame_receiver.sv
// tb/tb_gmii_rx_frame_receiver.sv - scoreboard bench for gmii_rx_frame_receiver with a frame-level reference model
module tb_gmii_rx_frame_receiver;

    logic clk = 1'b0;
    logic rst;
    always #4 clk = ~clk;

    gmii_rx_frame_receiver_if bus();

    gmii_rx_frame_receiver #(
        .MIN_FRAME_BYTES(64),
        .MAX_FRAME_BYTES(1518)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t      exp_beats[$];
    logic       exp_stat[$];
    logic [7:0] tx[$];
    bit         fcs_ok;
    bit         chk_zero = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    beat_t      mb;
    logic       me;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard Ethernet CRC-32 of the payload, transmitted complemented and LSB byte first
    function automatic logic [31:0] calc_fcs();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (tx[i]) begin
            c = c ^ {24'h0, tx[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int plen, input bit ramp);
        logic [31:0] f;
        tx.delete();
        for (int i = 0; i < plen; i++) tx.push_back(ramp ? 8'(i) : 8'($urandom));
        f = calc_fcs();
        tx.push_back(f[7:0]);
        tx.push_back(f[15:8]);
        tx.push_back(f[23:16]);
        tx.push_back(f[31:24]);
        fcs_ok = 1'b1;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic err, input logic r);
        @(posedge clk);
        #1;
        if (chk_zero) begin
            chk("reset_tvalid", bus.o_m_axis_tvalid, 0);
            chk("reset_tlast",  bus.o_m_axis_tlast, 0);
            chk("reset_good",   bus.o_frame_good, 0);
            chk("reset_bad",    bus.o_frame_bad, 0);
            chk_zero = 1'b0;
        end
        bus.i_gmii_rx_dv  = dv;
        bus.i_gmii_rx_d   = d;
        bus.i_gmii_rx_err = err;
        rst               = r;
    endtask

    task automatic send(input int err_at, input int bad_pre, input int gap, input int rst_at);
        int n;
        bit bad;
        n   = tx.size();
        bad = !fcs_ok || (err_at >= 0) || (n < 64) || (n > 1518);
        if (bad_pre < 0) begin
            if (rst_at >= 0) begin
                for (int k = 0; k <= rst_at - 6; k++) exp_beats.push_back({tx[k], 1'b0, 1'b0});
            end else begin
                for (int k = 0; k <= n - 5; k++)
                    exp_beats.push_back({tx[k], 1'(k == n - 5), 1'((k == n - 5) && bad)});
                exp_stat.push_back(bad);
            end
        end
        for (int i = 0; i < 7; i++) drive(1'b1, (i == bad_pre) ? 8'h57 : 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                drive(1'b1, tx[i], 1'b0, 1'b1);
                chk_zero = 1'b1;
            end else begin
                drive(1'b1, tx[i], 1'(i == err_at), 1'b0);
            end
        end
        repeat (gap) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (bus.o_m_axis_tvalid) begin
            if (exp_beats.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat at %0t",
                         bus.o_m_axis_tdata, bus.o_m_axis_tlast, $time);
            end else begin
                mb = exp_beats.pop_front();
                chk("tdata", bus.o_m_axis_tdata, mb.data);
                chk("tlast", bus.o_m_axis_tlast, mb.last);
                if (mb.last) chk("tuser", bus.o_m_axis_tuser, mb.user);
            end
            if (bus.o_m_axis_tlast) chk("pulse_with_tlast", bus.o_frame_good | bus.o_frame_bad, 1);
        end
        if (bus.o_frame_good || bus.o_frame_bad) begin
            if (exp_stat.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_status: got good %0b bad %0b, expected no pulse at %0t",
                         bus.o_frame_good, bus.o_frame_bad, $time);
            end else begin
                me = exp_stat.pop_front();
                chk("status", {bus.o_frame_good, bus.o_frame_bad}, {~me, me});
            end
        end
    end

    initial begin
        int plen, err_at, bad_pre, idx;
        rst               = 1'b1;
        bus.i_gmii_rx_dv  = 1'b0;
        bus.i_gmii_rx_d   = 8'h00;
        bus.i_gmii_rx_err = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_tdata",  bus.o_m_axis_tdata, 0);
        chk("rst_tvalid", bus.o_m_axis_tvalid, 0);
        chk("rst_tlast",  bus.o_m_axis_tlast, 0);
        chk("rst_tuser",  bus.o_m_axis_tuser, 0);
        chk("rst_good",   bus.o_frame_good, 0);
        chk("rst_bad",    bus.o_frame_bad, 0);
        rst = 1'b0;
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);

        build(60, 1'b1);  send(-1, -1, 1, -1);
        build(60, 1'b1);  tx[10] = 8'hFF; fcs_ok = 1'b0; send(-1, -1, 1, -1);
        build(96, 1'b0);  send(30, -1, 1, -1);
        build(0, 1'b0);   send(-1, -1, 1, -1);
        build(36, 1'b0);  send(-1, -1, 1, -1);
        build(60, 1'b0);  send(-1, -1, 1, -1);
        build(60, 1'b0);  send(-1, -1, 1, -1);
        build(60, 1'b0);  send(-1, 3, 1, -1);
        build(59, 1'b0);  send(-1, -1, 2, -1);
        build(1514, 1'b0); send(-1, -1, 1, -1);
        build(1515, 1'b0); send(-1, -1, 1, -1);
        build(60, 1'b0);  send(-1, -1, 2, 20);
        build(60, 1'b0);  send(-1, -1, 1, -1);

        for (int f = 0; f < 30; f++) begin
            plen = $urandom_range(0, 100);
            build(plen, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, tx.size() - 1);
                tx[idx] = tx[idx] ^ 8'(1 << $urandom_range(0, 7));
                fcs_ok = 1'b0;
            end
            err_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, tx.size() - 1) : -1;
            bad_pre = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
            send(err_at, bad_pre, $urandom_range(1, 3), -1);
        end

        for (int i = 0; i < 50 && (exp_beats.size() != 0 || exp_stat.size() != 0); i++)
            drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("beats_outstanding",  exp_beats.size(), 0);
        chk("status_outstanding", exp_stat.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
